// File: rtl/spi_xfer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_sequencer_pkg
// Purpose  : Shared types and constants for the SPI transfer sequencer:
//            the sequencer state encoding and the byte-count decode where a
//            length of 0 stands for a full 256-byte transfer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_xfer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_FETCH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_STORE = 3'd5,
    ST_HOLD  = 3'd6
  } state_e;

  localparam int         C_CNT_W        = 9;
  localparam logic [8:0] C_LEN_ZERO_CNT = 9'd256;

  // An 8-bit length field cannot express 256, so zero is reused for it.
  function automatic logic [C_CNT_W-1:0] decode_len(input logic [7:0] len);
    return (len == 8'd0) ? C_LEN_ZERO_CNT : {1'b0, len};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_sequencer
// Purpose  : Sequences multi-byte SPI transactions on top of an existing SPI
//            byte engine: drives slave selects with setup/hold spacing,
//            streams tx bytes into the engine and rx bytes out to the user.
// Ports    : clk, resetn        - clock, async active-low reset
//            cmd_*              - transaction request (slave, length, keep)
//            tx_*               - outgoing byte stream (valid/ready)
//            rx_*               - incoming byte stream (valid/ready)
//            done, busy         - transaction status
//            eng_*              - byte engine start/data/ready/done-tick
//            spi_ss_n           - active-low slave selects
// Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer
  import spi_xfer_sequencer_pkg::*;
#(
  parameter int  NSLAVE    = 2,
  parameter int  SETUP_CYC = 4,
  parameter int  HOLD_CYC  = 4,
  localparam int SS_W      = (NSLAVE > 1) ? $clog2(NSLAVE) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SS_W-1:0]   cmd_ss,
  input  logic [7:0]        cmd_len,
  input  logic              cmd_keep,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              done,
  output logic              busy,
  output logic              eng_start,
  output logic [7:0]        eng_din,
  input  logic [7:0]        eng_dout,
  input  logic              eng_ready,
  input  logic              eng_done_tick,
  output logic [NSLAVE-1:0] spi_ss_n
);

  // Timers count down to zero, so they are loaded with (cycles - 1).
  localparam logic [7:0] C_SETUP_LOAD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] C_HOLD_LOAD  = 8'(HOLD_CYC - 1);

  state_e              state_q, state_d;
  logic [SS_W-1:0]     ss_q, ss_d;
  logic                keep_q, keep_d;
  logic                held_q, held_d;
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]          tmr_q, tmr_d;
  logic [7:0]          eng_din_q, eng_din_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [NSLAVE-1:0]   ss_n_q, ss_n_d;
  logic                done_q, done_d;

  logic [NSLAVE-1:0]   sel_n;
  logic                held_match;
  logic                rx_free;

  // One-cold select for the requested slave; out-of-range indices select none.
  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NSLAVE; i++) begin
      if (cmd_ss == SS_W'(i)) sel_n[i] = 1'b0;
    end
  end

  // A slave still selected from a kept transaction needs no new setup time.
  assign held_match = held_q && (cmd_ss == ss_q);
  // The rx slot is free now, or is being drained this very cycle.
  assign rx_free    = !rx_valid_q || rx_ready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid) state_d = held_match ? ST_FETCH : ST_SETUP;
      ST_SETUP: if (tmr_q == 8'd0) state_d = ST_FETCH;
      ST_FETCH: if (tx_valid && eng_ready) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (eng_done_tick) state_d = ST_STORE;
      ST_STORE: begin
        if (rx_free) begin
          if (cnt_q != '0)  state_d = ST_FETCH;
          else if (keep_q)  state_d = ST_IDLE;
          else              state_d = ST_HOLD;
        end
      end
      ST_HOLD:  if (tmr_q == 8'd0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    tx_ready  = (state_q == ST_FETCH) && eng_ready;
    eng_start = (state_q == ST_START);
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    ss_d       = ss_q;
    keep_d     = keep_q;
    held_d     = held_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    eng_din_d  = eng_din_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ss_n_d     = ss_n_q;
    done_d     = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ss_d   = cmd_ss;
          keep_d = cmd_keep;
          held_d = 1'b0;
          cnt_d  = decode_len(cmd_len);
          // Switching slaves swaps selects in one edge and pays full setup.
          if (!held_match) begin
            ss_n_d = sel_n;
            tmr_d  = C_SETUP_LOAD;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_q != 8'd0) tmr_d = tmr_q - 8'd1;
      end
      ST_FETCH: begin
        if (tx_valid && eng_ready) eng_din_d = tx_data;
      end
      ST_WAIT: begin
        // Only reachable with the rx slot empty, so capture never collides
        // with a drain handshake.
        if (eng_done_tick) begin
          rx_data_d  = eng_dout;
          rx_valid_d = 1'b1;
          cnt_d      = cnt_q - 9'd1;
        end
      end
      ST_STORE: begin
        if (rx_free && (cnt_q == '0)) begin
          if (keep_q) begin
            held_d = 1'b1;
            done_d = 1'b1;
          end else begin
            tmr_d  = C_HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (tmr_q == 8'd0) begin
          ss_n_d = '1;
          done_d = 1'b1;
        end else begin
          tmr_d  = tmr_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ss_q       <= '0;
      keep_q     <= 1'b0;
      held_q     <= 1'b0;
      cnt_q      <= '0;
      tmr_q      <= 8'd0;
      eng_din_q  <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      ss_n_q     <= '1;
      done_q     <= 1'b0;
    end else begin
      ss_q       <= ss_d;
      keep_q     <= keep_d;
      held_q     <= held_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      eng_din_q  <= eng_din_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ss_n_q     <= ss_n_d;
      done_q     <= done_d;
    end
  end

  assign eng_din  = eng_din_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign done     = done_q;
  assign spi_ss_n = ss_n_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer_sequencer
// Purpose  : Directed self-checking bench for spi_xfer_sequencer with a
//            loopback byte-engine model (eng_dout echoes eng_din).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sequencer;

  localparam int ENG_LAT = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [0:0] cmd_ss = 1'b0;
  logic [7:0] cmd_len = 8'd0;
  logic       cmd_keep = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b1;

  logic       cmd_ready, tx_ready, rx_valid, done, busy, eng_start;
  logic [7:0] rx_data, eng_din;
  logic [1:0] spi_ss_n;

  // Byte engine model
  logic       eng_ready_q = 1'b1;
  logic       eng_tick_q  = 1'b0;
  logic [7:0] eng_dout_q  = 8'd0;
  logic [7:0] eng_lat     = 8'd0;
  int         eng_cnt     = 0;
  logic       eng_block   = 1'b0;
  logic       spur        = 1'b0;
  logic       eng_ready, eng_done_tick;
  logic [7:0] eng_dout;

  assign eng_ready     = eng_ready_q & ~eng_block;
  assign eng_done_tick = eng_tick_q | spur;
  assign eng_dout      = spur ? 8'h3C : eng_dout_q;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    eng_tick_q <= 1'b0;
    if (eng_start) begin
      eng_lat     <= eng_din;
      eng_ready_q <= 1'b0;
      eng_cnt     <= ENG_LAT;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_tick_q  <= 1'b1;
        eng_dout_q  <= eng_lat;
        eng_ready_q <= 1'b1;
      end
    end
  end

  spi_xfer_sequencer dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ss(cmd_ss),
    .cmd_len(cmd_len), .cmd_keep(cmd_keep),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .done(done), .busy(busy),
    .eng_start(eng_start), .eng_din(eng_din), .eng_dout(eng_dout),
    .eng_ready(eng_ready), .eng_done_tick(eng_done_tick),
    .spi_ss_n(spi_ss_n)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_start, n_done, n_rx, tx_ptr;
  logic [7:0] tx_mem [0:511];
  logic [7:0] rx_log [0:511];

  task automatic clr();
    n_start = 0; n_done = 0; n_rx = 0; tx_ptr = 0;
    tx_data = tx_mem[0];
  endtask

  // Record this cycle's events, advance one clock, present the next tx byte.
  task automatic step();
    bit tx_hs;
    if (eng_start) n_start++;
    if (done) n_done++;
    if (rx_valid && rx_ready) begin rx_log[n_rx] = rx_data; n_rx++; end
    tx_hs = tx_valid && tx_ready;
    @(posedge clk); #2;
    if (tx_hs) begin tx_ptr++; tx_data = tx_mem[tx_ptr]; end
  endtask

  task automatic issue(input logic ss, input logic [7:0] len, input logic keep);
    cmd_ss = ss; cmd_len = len; cmd_keep = keep; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    eng_block = 1'b1;
    resetn = 1'b0;
    @(posedge clk); #2;
    n_cmp++; if (spi_ss_n !== 2'b11) begin n_fail++; $display("FAIL rst_ss_n: got %b want 11", spi_ss_n); end
    n_cmp++; if ({rx_valid, done, eng_start, busy} !== 4'b0000) begin n_fail++;
      $display("FAIL rst_flags: got rxv/done/start/busy=%b want 0000", {rx_valid, done, eng_start, busy}); end
    n_cmp++; if ({rx_data, eng_din} !== 16'h0000) begin n_fail++; $display("FAIL rst_data: got %h want 0000", {rx_data, eng_din}); end
    resetn = 1'b1;
    step();
    n_cmp++; if ({cmd_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL rst_release: got ready/busy=%b want 10", {cmd_ready, busy}); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ready: got %b want 0 (engine not ready)", tx_ready); end
    eng_block = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, g;
    bit ok;
    tx_mem[0] = 8'hA5; tx_mem[1] = 8'h5A; tx_mem[2] = 8'hFF;
    clr(); tx_valid = 1'b1; rx_ready = 1'b1;
    issue(1'b1, 8'd3, 1'b0);
    n_cmp++; if (spi_ss_n !== 2'b01) begin n_fail++; $display("FAIL basic_ss_assert: got %b want 01", spi_ss_n); end
    n_cmp++; if ({busy, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL basic_busy: got busy/ready=%b want 10", {busy, cmd_ready}); end
    lat = 0;
    while (!eng_start && lat < 50) begin step(); lat++; end
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL basic_setup_lat: got %0d want 5", lat); end
    g = 0;
    while (n_rx < 3 && g < 300) begin step(); g++; end
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (spi_ss_n !== 2'b01 || done !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      step();
    end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got early release want 4 hold cycles"); end
    n_cmp++; if ({done, busy, spi_ss_n} !== 4'b1011) begin n_fail++;
      $display("FAIL basic_end: got done/busy/ss_n=%b want 1011", {done, busy, spi_ss_n}); end
    step();
    n_cmp++; if (done !== 1'b0 || n_done !== 1) begin n_fail++; $display("FAIL basic_done_once: got done=%b count=%0d want 0/1", done, n_done); end
    n_cmp++; if ({rx_log[0], rx_log[1], rx_log[2]} !== 24'hA55AFF) begin n_fail++;
      $display("FAIL basic_rx: got %h want a55aff", {rx_log[0], rx_log[1], rx_log[2]}); end
    n_cmp++; if (n_start !== 3) begin n_fail++; $display("FAIL basic_starts: got %0d want 3", n_start); end
  endtask

  task automatic test_len256();
    int g, bad;
    for (int i = 0; i < 256; i++) tx_mem[i] = 8'(i);
    clr(); tx_valid = 1'b1; rx_ready = 1'b1;
    issue(1'b0, 8'd0, 1'b0);
    g = 0;
    while (n_done == 0 && g < 6000) begin step(); g++; end
    repeat (3) step();
    n_cmp++; if (n_start !== 256) begin n_fail++; $display("FAIL len256_starts: got %0d want 256", n_start); end
    n_cmp++; if (n_rx !== 256) begin n_fail++; $display("FAIL len256_rx_count: got %0d want 256", n_rx); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (rx_log[i] !== 8'(i)) bad++;
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL len256_rx_data: got %0d wrong bytes want 0", bad); end
    n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL len256_done: got %0d want 1", n_done); end
  endtask

  task automatic test_rx_backpressure();
    int g;
    bit ok;
    tx_mem[0] = 8'h11; tx_mem[1] = 8'h22;
    clr(); tx_valid = 1'b1; rx_ready = 1'b0;
    issue(1'b0, 8'd2, 1'b0);
    g = 0;
    while (!rx_valid && g < 100) begin step(); g++; end
    n_cmp++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin n_fail++;
      $display("FAIL bp_first: got v=%b d=%h want 1/11", rx_valid, rx_data); end
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rx_valid !== 1'b1 || rx_data !== 8'h11 || eng_start !== 1'b0) ok = 1'b0;
    end
    n_cmp++; if (ok !== 1'b1 || n_start !== 1) begin n_fail++;
      $display("FAIL bp_stall: got stable=%b starts=%0d want 1/1", ok, n_start); end
    rx_ready = 1'b1;
    g = 0;
    while (n_done == 0 && g < 200) begin step(); g++; end
    n_cmp++; if ({rx_log[0], rx_log[1]} !== 16'h1122 || n_start !== 2) begin n_fail++;
      $display("FAIL bp_resume: got rx=%h starts=%0d want 1122/2", {rx_log[0], rx_log[1]}, n_start); end
  endtask

  task automatic test_keep();
    int lat, g;
    bit ok;
    tx_mem[0] = 8'hC1; tx_mem[1] = 8'hC2; tx_mem[2] = 8'hC3;
    clr(); tx_valid = 1'b1; rx_ready = 1'b1;
    issue(1'b0, 8'd1, 1'b1);
    ok = 1'b1; g = 0;
    while (!done && g < 100) begin if (spi_ss_n !== 2'b10) ok = 1'b0; step(); g++; end
    n_cmp++; if (ok !== 1'b1 || spi_ss_n !== 2'b10 || busy !== 1'b0) begin n_fail++;
      $display("FAIL keep_first: got held=%b ss_n=%b busy=%b want 1/10/0", ok, spi_ss_n, busy); end
    issue(1'b0, 8'd1, 1'b1);
    lat = 0; ok = 1'b1;
    while (!eng_start && lat < 50) begin if (spi_ss_n !== 2'b10) ok = 1'b0; step(); lat++; end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL keep_skip_setup: got lat %0d want 1", lat); end
    g = 0;
    while (!done && g < 100) begin if (spi_ss_n !== 2'b10) ok = 1'b0; step(); g++; end
    n_cmp++; if (ok !== 1'b1 || spi_ss_n !== 2'b10) begin n_fail++;
      $display("FAIL keep_second_held: got held=%b ss_n=%b want 1/10", ok, spi_ss_n); end
    issue(1'b1, 8'd1, 1'b0);
    n_cmp++; if (spi_ss_n !== 2'b01) begin n_fail++; $display("FAIL keep_switch: got %b want 01", spi_ss_n); end
    lat = 0;
    while (!eng_start && lat < 50) begin step(); lat++; end
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL keep_switch_setup: got lat %0d want 5", lat); end
    g = 0;
    while (!done && g < 100) begin step(); g++; end
    step();
    n_cmp++; if (spi_ss_n !== 2'b11 || n_done !== 3) begin n_fail++;
      $display("FAIL keep_end: got ss_n=%b dones=%0d want 11/3", spi_ss_n, n_done); end
    n_cmp++; if ({rx_log[0], rx_log[1], rx_log[2]} !== 24'hC1C2C3) begin n_fail++;
      $display("FAIL keep_rx: got %h want c1c2c3", {rx_log[0], rx_log[1], rx_log[2]}); end
  endtask

  task automatic test_fetch_stall();
    int g;
    bit ok;
    tx_mem[0] = 8'h44; tx_mem[1] = 8'h55;
    clr(); tx_valid = 1'b0; rx_ready = 1'b1;
    issue(1'b0, 8'd2, 1'b0);
    repeat (4) step();
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (spi_ss_n !== 2'b10 || eng_start !== 1'b0 || rx_valid !== 1'b0) ok = 1'b0;
      if (i == 3) spur = 1'b1;
      step();
      spur = 1'b0;
    end
    n_cmp++; if (ok !== 1'b1 || rx_valid !== 1'b0) begin n_fail++;
      $display("FAIL stall_hold: got ok=%b rx_valid=%b want 1/0", ok, rx_valid); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL stall_tx_ready: got %b want 1", tx_ready); end
    tx_valid = 1'b1;
    step();
    n_cmp++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got eng_start %b want 1", eng_start); end
    g = 0;
    while (n_done == 0 && g < 200) begin step(); g++; end
    n_cmp++; if ({rx_log[0], rx_log[1]} !== 16'h4455 || n_rx !== 2 || n_start !== 2) begin n_fail++;
      $display("FAIL stall_rx: got rx=%h n=%0d starts=%0d want 4455/2/2", {rx_log[0], rx_log[1]}, n_rx, n_start); end
  endtask

  task automatic test_reset_mid();
    int g;
    bit ok;
    tx_mem[0] = 8'h01; tx_mem[1] = 8'h02; tx_mem[2] = 8'h03;
    clr(); tx_valid = 1'b1; rx_ready = 1'b1;
    issue(1'b0, 8'd3, 1'b0);
    g = 0;
    while (n_start < 2 && g < 200) begin step(); g++; end
    #1 resetn = 1'b0;
    #1;
    n_cmp++; if ({spi_ss_n, rx_valid, busy, done} !== 5'b11000) begin n_fail++;
      $display("FAIL rstmid_async: got ss_n/rxv/busy/done=%b want 11000", {spi_ss_n, rx_valid, busy, done}); end
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0 || rx_valid !== 1'b0 || spi_ss_n !== 2'b11) ok = 1'b0;
      step();
    end
    n_cmp++; if (ok !== 1'b1 || n_start !== 2 || cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_quiet: got ok=%b starts=%0d ready=%b want 1/2/1", ok, n_start, cmd_ready); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) tx_mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_len256();
    test_rx_backpressure();
    test_keep();
    test_fetch_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
